// File: rtl/sobel_ap_ctrl.sv
// Purpose: CSR window and ap_ctrl_hs start/done sequencer for the Sobel core, with run stats and watchdog.
// Latency: bus_ack_o combinational, read data one cycle after ack; ap_start_o one cycle after a START write.
// Backpressure: none on the bus (every hit is acked at once); ap_start_o holds until the core returns ap_ready_i.
module sobel_ap_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h00000010,
  parameter logic [31:0] WDT_CYCLES  = 32'd0,
  parameter int unsigned SRST_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        ap_start_o,
  output logic        ap_rst_o,
  input  logic        ap_ready_i,
  input  logic        ap_done_i,
  input  logic        ap_idle_i,
  output logic        irq_o
);

  localparam int SW = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;
  localparam logic [SW-1:0] SRST_LAST = SW'(SRST_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [31:0]   runs_q, runs_d;
  logic [SW-1:0] srst_q, srst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic          ie_q, ie_d;
  logic          irq_q;
  logic          resp_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rd_val;

  logic        hit, rd_req, wr_ctrl, wr_start, wr_clr, busy, wdt_hit;
  logic [31:0] cnt_inc;
  logic        unused_bits;

  // Byte enables, sub-word address bits and upper CTRL data bits carry no meaning here.
  assign unused_bits = ^{bus_be_bi, bus_addr_bi[1:0], bus_wdata_bi[31:3]};

  assign hit       = bus_req_i && (bus_addr_bi[31:4] == BASE_ADDR[31:4]);
  assign rd_req    = hit && !bus_we_i;
  assign wr_ctrl   = hit && bus_we_i && (bus_addr_bi[3:2] == 2'd0);
  assign wr_start  = wr_ctrl && bus_wdata_bi[0];
  assign wr_clr    = wr_ctrl && bus_wdata_bi[1];
  assign busy      = (state_q != S_IDLE);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  assign wdt_hit   = (WDT_CYCLES != 32'd0) && (cnt_q == WDT_CYCLES - 32'd1);

  assign bus_ack_o    = hit;
  assign bus_resp_o   = resp_q;
  assign bus_rdata_bo = rdata_q;
  assign ap_start_o   = (state_q == S_START);
  assign ap_rst_o     = (state_q == S_FAULT);
  assign irq_o        = irq_q;

  // Next-state and register updates; CLR is applied before any set so a set in the same cycle wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    runs_d   = runs_q;
    srst_d   = srst_q;
    done_d   = done_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    ie_d     = ie_q;
    if (wr_clr) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      tmo_d  = 1'b0;
    end
    if (wr_ctrl) ie_d = bus_wdata_bi[2];
    case (state_q)
      S_IDLE: begin
        if (wr_start) begin
          state_d = S_START;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      S_START, S_WAIT_DONE: begin
        if (wr_start) err_d = 1'b1;
        cnt_d = cnt_inc;
        // ap_ctrl_hs never raises done before the start was taken, so done alone completes the run.
        if (ap_done_i) begin
          state_d  = S_IDLE;
          cycles_d = cnt_inc;
          runs_d   = runs_q + 32'd1;
          done_d   = 1'b1;
        end else if (wdt_hit) begin
          state_d  = S_FAULT;
          cycles_d = WDT_CYCLES;
          tmo_d    = 1'b1;
          srst_d   = '0;
        end else if (state_q == S_START && ap_ready_i) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_FAULT: begin
        if (wr_start) err_d = 1'b1;
        srst_d = srst_q + SW'(1);
        if (srst_q == SRST_LAST) begin
          state_d = S_IDLE;
          srst_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read mux over the current register values.
  always_comb begin
    rd_val = '0;
    case (bus_addr_bi[3:2])
      2'd0: rd_val = {29'b0, ie_q, 2'b0};
      2'd1: rd_val = {27'b0, err_q, tmo_q, ap_idle_i, done_q, busy};
      2'd2: rd_val = cycles_q;
      2'd3: rd_val = runs_q;
      default: rd_val = '0;
    endcase
  end

  // State and CSR registers; irq follows the next DONE/IE so CLR drops it one cycle later.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cycles_q <= '0;
      runs_q   <= '0;
      srst_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      ie_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      runs_q   <= runs_d;
      srst_q   <= srst_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      ie_q     <= ie_d;
      irq_q    <= ie_d & done_d;
    end
  end

  // Read response one cycle after the acked read; data is forced to zero outside a response.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q  <= rd_req;
      rdata_q <= rd_req ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_sobel_ap_ctrl.sv
// Purpose: directed self-checking bench for sobel_ap_ctrl with a scripted core handshake.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge after the rising edge.
// Backpressure: the bench plays the ap_ctrl_hs core, asserting ready/done at fixed cycle offsets.
module tb_sobel_ap_ctrl;

  localparam logic [31:0] A_CTRL   = 32'h10;
  localparam logic [31:0] A_STATUS = 32'h14;
  localparam logic [31:0] A_CYCLES = 32'h18;
  localparam logic [31:0] A_RUNS   = 32'h1C;

  logic        clk_gen = 1'b0;
  logic        arst_n;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_resp;
  logic [31:0] bus_rdata;
  logic        ap_start, ap_rst, ap_ready, ap_done, ap_idle, irq;

  int n_cmp = 0;
  int n_err = 0;

  sobel_ap_ctrl #(
    .BASE_ADDR  (32'h00000010),
    .WDT_CYCLES (32'd50),
    .SRST_CYCLES(4)
  ) dut (
    .clk_i       (clk_gen),
    .arst_n_i    (arst_n),
    .bus_req_i   (bus_req),
    .bus_we_i    (bus_we),
    .bus_addr_bi (bus_addr),
    .bus_be_bi   (bus_be),
    .bus_wdata_bi(bus_wdata),
    .bus_ack_o   (bus_ack),
    .bus_resp_o  (bus_resp),
    .bus_rdata_bo(bus_rdata),
    .ap_start_o  (ap_start),
    .ap_rst_o    (ap_rst),
    .ap_ready_i  (ap_ready),
    .ap_done_i   (ap_done),
    .ap_idle_i   (ap_idle),
    .irq_o       (irq)
  );

  always #5 clk_gen = ~clk_gen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_gen);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    #1 chk("wr_ack", 32'(bus_ack), 32'd1);
    @(negedge clk_gen);
    bus_req = 1'b0; bus_we = 1'b0;
    chk("wr_no_resp", 32'(bus_resp), 32'd0);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk_gen);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
    #1 chk("rd_ack", 32'(bus_ack), 32'd1);
    chk("rd_resp_early", 32'(bus_resp), 32'd0);
    @(negedge clk_gen);
    bus_req = 1'b0;
    chk("rd_resp", 32'(bus_resp), 32'd1);
    d = bus_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(tag, d, exp);
  endtask

  // Core model: cycle k counts from the first ap_start cycle; returns the number of ap_start cycles seen.
  task automatic run_core(input int rdy_k, input int done_k, input int n, output int starts);
    starts = 0;
    for (int k = 0; k < n; k++) begin
      ap_ready = (k == rdy_k);
      ap_done  = (k == done_k);
      if (ap_start) starts++;
      @(negedge clk_gen);
    end
    ap_ready = 1'b0;
    ap_done  = 1'b0;
  endtask

  initial begin
    int starts, first_rst, rst_len;
    logic [31:0] d;
    arst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    bus_be = 4'hF; ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
    repeat (2) @(negedge clk_gen);
    chk("rst_start", 32'(ap_start), 32'd0);
    chk("rst_aprst", 32'(ap_rst), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    arst_n = 1'b1;

    // Reset state visible through the bus.
    rd_chk("status_reset", A_STATUS, 32'h4);
    rd_chk("runs_reset", A_RUNS, 32'h0);

    // Miss outside the window is neither acked nor answered.
    @(negedge clk_gen);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'h20;
    #1 chk("miss_ack", 32'(bus_ack), 32'd0);
    @(negedge clk_gen);
    bus_req = 1'b0;
    chk("miss_resp", 32'(bus_resp), 32'd0);

    // Sideband done/ready in IDLE does nothing.
    ap_ready = 1'b1; ap_done = 1'b1;
    @(negedge clk_gen);
    ap_ready = 1'b0; ap_done = 1'b0;
    rd_chk("idle_sideband_runs", A_RUNS, 32'h0);
    rd_chk("idle_sideband_status", A_STATUS, 32'h4);

    // Normal run: ready at +3, done at +10.
    ap_idle = 1'b0;
    bus_wr(A_CTRL, 32'h1);
    run_core(3, 10, 12, starts);
    chk("run1_start_len", 32'(starts), 32'd4);
    rd_chk("run1_status", A_STATUS, 32'h2);
    rd_chk("run1_cycles", A_CYCLES, 32'd11);
    rd_chk("run1_runs", A_RUNS, 32'd1);

    // Ready and done together on the first START cycle.
    bus_wr(A_CTRL, 32'h1);
    run_core(0, 0, 1, starts);
    chk("run2_start_len", 32'(starts), 32'd1);
    rd_chk("run2_status", A_STATUS, 32'h2);
    rd_chk("run2_cycles", A_CYCLES, 32'd1);
    rd_chk("run2_runs", A_RUNS, 32'd2);

    // Second START two cycles later is rejected and flags ERR.
    bus_wr(A_CTRL, 32'h1);
    bus_wr(A_CTRL, 32'h1);
    run_core(1, 4, 6, starts);
    rd_chk("err_cycles", A_CYCLES, 32'd7);
    rd_chk("err_runs", A_RUNS, 32'd3);
    rd_chk("err_status", A_STATUS, 32'h12);
    bus_wr(A_CTRL, 32'h2);
    rd_chk("clr_status", A_STATUS, 32'h0);

    // Watchdog: no done ever arrives.
    bus_wr(A_CTRL, 32'h1);
    first_rst = -1;
    rst_len = 0;
    for (int k = 0; k < 60; k++) begin
      ap_ready = (k == 2);
      if (ap_rst) begin
        if (first_rst < 0) first_rst = k;
        rst_len++;
      end
      @(negedge clk_gen);
    end
    ap_ready = 1'b0;
    chk("wdt_rst_first", 32'(first_rst), 32'd50);
    chk("wdt_rst_len", 32'(rst_len), 32'd4);
    rd_chk("wdt_status", A_STATUS, 32'h8);
    rd_chk("wdt_cycles", A_CYCLES, 32'd50);
    rd_chk("wdt_runs", A_RUNS, 32'd3);
    bus_wr(A_CTRL, 32'h1);
    chk("wdt_restart", 32'(ap_start), 32'd1);
    run_core(0, 0, 1, starts);
    rd_chk("wdt_restart_runs", A_RUNS, 32'd4);

    // Interrupt: IE + START, complete, then CLR.
    bus_wr(A_CTRL, 32'h5);
    run_core(1, 2, 3, starts);
    chk("irq_set", 32'(irq), 32'd1);
    rd_chk("ctrl_ie", A_CTRL, 32'h4);
    @(negedge clk_gen);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = A_CTRL; bus_wdata = 32'h6;
    #1 chk("irq_clr_cycle", 32'(irq), 32'd1);
    @(negedge clk_gen);
    bus_req = 1'b0; bus_we = 1'b0;
    chk("irq_clr_next", 32'(irq), 32'd0);

    // Reset mid-run in WAIT_DONE with a read response in flight.
    bus_wr(A_CTRL, 32'h5);
    run_core(1, -1, 3, starts);
    @(negedge clk_gen);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_RUNS;
    @(negedge clk_gen);
    bus_req = 1'b0;
    chk("pre_rst_resp", 32'(bus_resp), 32'd1);
    chk("pre_rst_rdata", bus_rdata, 32'd5);
    chk("pre_rst_wait", 32'(ap_start), 32'd0);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_resp", 32'(bus_resp), 32'd0);
    chk("arst_rdata", bus_rdata, 32'd0);
    chk("arst_start", 32'(ap_start), 32'd0);
    chk("arst_aprst", 32'(ap_rst), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_ack", 32'(bus_ack), 32'd0);
    @(negedge clk_gen);
    arst_n = 1'b1;
    ap_idle = 1'b1;
    rd_chk("post_rst_status", A_STATUS, 32'h4);
    rd_chk("post_rst_runs", A_RUNS, 32'd0);
    rd_chk("post_rst_ctrl", A_CTRL, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
